pipeline_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage pipeline. Generates the load-enable and flush strobes for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory accesses with a bounded wait. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load enables and
// bubble strobes for PC and the pipeline registers, load-use and branch
// hazard resolution, bounded data-memory wait, stall counter and sticky
// memory-timeout flag.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_wb_flush,
  output logic                   dmem_start,
  output logic                   mem_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              err_set;
  logic              normal;
  logic              freeze;
  logic              load_use;

  // Load in EX whose destination is read by the instruction in ID
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  // Next-state and Mealy strobe generation
  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    err_set      = 1'b0;
    normal       = 1'b0;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_start   = 1'b0;

    case (state)
      RUN: begin
        if (dmem_req) begin
          freeze     = 1'b1;
          dmem_start = 1'b1;
          state_nxt  = MEM_WAIT;
          wcnt_nxt   = '0;
        end else begin
          normal = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          normal    = 1'b1;
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          // Forced release: drop the never-arriving read data
          normal       = 1'b1;
          mem_wb_flush = 1'b1;
          err_set      = 1'b1;
          state_nxt    = RUN;
          wcnt_nxt     = '0;
        end else begin
          freeze   = 1'b1;
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase

    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end

    // Branch squash outranks the load-use bubble
    if (normal) begin
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    // Held in reset: nothing loads, every stage bubbles
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      dmem_start   = 1'b0;
    end
  end

  // State, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      wcnt         <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (err_set) begin
        mem_error <= 1'b1;
      end
      if (!pc_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard, memory-wait,
// timeout, reset and saturation sequences with a queue of expected strobes.
module tb_pipeline_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned SW  = 4;
  localparam int          SAT = (1 << SW) - 1;

  // {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_flush,id_ex_flush,mem_wb_flush,dmem_start}
  localparam logic [8:0] V_RUN = 9'b11111_000_0;
  localparam logic [8:0] V_FRZ = 9'b00000_000_0;
  localparam logic [8:0] V_STA = 9'b00000_000_1;
  localparam logic [8:0] V_LU  = 9'b00111_010_0;
  localparam logic [8:0] V_BR  = 9'b11111_110_0;
  localparam logic [8:0] V_TO  = 9'b11111_001_0;
  localparam logic [8:0] V_RST = 9'b00000_111_0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic          branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_flush, dmem_start, mem_error;
  logic [SW-1:0] stall_cycles;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_stall = 0;
  logic          exp_err  = 1'b0;
  logic [8:0]    exp_q[$];

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .dmem_start(dmem_start), .mem_error(mem_error),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hazard-field presets: 0 no load, 1 rs hit, 2 ex_rt=0, 3 rt hit, 4 rs match but unused
  task automatic set_haz(input int kind);
    ex_mem_read = (kind != 0);
    id_uses_rs  = (kind != 4);
    id_uses_rt  = 1'b1;
    case (kind)
      2:       begin ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; end
      3:       begin ex_rt = 5'd7; id_rs = 5'd5; id_rt = 5'd7; end
      default: begin ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd6; end
    endcase
  endtask

  // One clock: drive, push expectation, sample mid-low-phase, update model
  task automatic step(input string tag, input int kind, input logic br,
                      input logic req, input logic rdy, input logic [8:0] exp);
    logic [8:0] e;
    @(negedge clk);
    set_haz(kind);
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
    exp_q.push_back(exp);
    #2;
    e = exp_q.pop_front();
    chk({tag, ".strb"}, int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                              if_id_flush, id_ex_flush, mem_wb_flush, dmem_start}), int'(e));
    chk({tag, ".stall"}, int'(stall_cycles), exp_stall);
    chk({tag, ".err"}, int'(mem_error), int'(exp_err));
    if (!e[8] && exp_stall != SAT) exp_stall++;
    if (e[1]) exp_err = 1'b1;
  endtask

  task automatic idle_inputs();
    set_haz(0);
    branch_taken = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  // Assert reset mid-phase, check immediate values, then release
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk({tag, ".strb"}, int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                              if_id_flush, id_ex_flush, mem_wb_flush, dmem_start}), int'(V_RST));
    chk({tag, ".stall"}, int'(stall_cycles), 0);
    chk({tag, ".err"}, int'(mem_error), 0);
    exp_stall = 0;
    exp_err   = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset("rst0");

    // Load-use and branch hazards
    step("idle",     0, 1'b0, 1'b0, 1'b0, V_RUN);
    step("lu_rs",    1, 1'b0, 1'b0, 1'b0, V_LU);
    step("lu_rt0",   2, 1'b0, 1'b0, 1'b0, V_RUN);
    step("lu_rt",    3, 1'b0, 1'b0, 1'b0, V_LU);
    step("lu_unuse", 4, 1'b0, 1'b0, 1'b0, V_RUN);
    step("br_lu",    1, 1'b1, 1'b0, 1'b0, V_BR);
    step("br",       0, 1'b1, 1'b0, 1'b0, V_BR);
    step("rdy_run",  0, 1'b0, 1'b0, 1'b1, V_RUN);

    // Access released on the 3rd wait cycle
    step("m3_c0",    0, 1'b0, 1'b1, 1'b0, V_STA);
    step("m3_c1",    0, 1'b0, 1'b1, 1'b0, V_FRZ);
    step("m3_c2",    0, 1'b0, 1'b1, 1'b0, V_FRZ);
    step("m3_c3",    0, 1'b0, 1'b1, 1'b1, V_RUN);
    step("m3_after", 0, 1'b0, 1'b0, 1'b0, V_RUN);

    // Freeze outranks hazards; hazards re-evaluated at release
    step("fz_c0",    1, 1'b1, 1'b1, 1'b0, V_STA);
    step("fz_rel",   1, 1'b0, 1'b1, 1'b1, V_LU);
    step("fz_rel_br",0, 1'b0, 1'b1, 1'b0, V_STA);
    step("fz_br",    1, 1'b1, 1'b1, 1'b1, V_BR);

    // Back-to-back accesses each get their own start
    step("bb_c0",    0, 1'b0, 1'b1, 1'b0, V_STA);
    step("bb_rel",   0, 1'b0, 1'b1, 1'b1, V_RUN);
    step("bb2_c0",   0, 1'b0, 1'b1, 1'b0, V_STA);
    step("bb2_rel",  0, 1'b0, 1'b1, 1'b1, V_RUN);

    // Timeout: TO freeze cycles then forced release with bubble
    step("to_c0",    0, 1'b0, 1'b1, 1'b0, V_STA);
    for (int i = 1; i < int'(TO); i++) step("to_wait", 0, 1'b0, 1'b1, 1'b0, V_FRZ);
    step("to_rel",   0, 1'b0, 1'b1, 1'b0, V_TO);
    step("to_after", 0, 1'b0, 1'b0, 1'b0, V_RUN);
    step("to2_c0",   0, 1'b0, 1'b1, 1'b0, V_STA);
    step("to2_rel",  0, 1'b0, 1'b1, 1'b1, V_RUN);
    step("to2_idle", 0, 1'b0, 1'b0, 1'b0, V_RUN);

    // Reset during the second MEM_WAIT cycle abandons the access
    step("rw_c0",    0, 1'b0, 1'b1, 1'b0, V_STA);
    step("rw_c1",    0, 1'b0, 1'b1, 1'b0, V_FRZ);
    do_reset("rw_rst");
    step("rw_run",   0, 1'b0, 1'b0, 1'b1, V_RUN);
    step("rw_idle",  0, 1'b0, 1'b0, 1'b0, V_RUN);
    step("rw_new",   0, 1'b0, 1'b1, 1'b0, V_STA);
    step("rw_rel",   0, 1'b0, 1'b1, 1'b1, V_RUN);

    // Saturation: 20 load-use stalls on a 4-bit counter
    do_reset("sat_rst");
    for (int i = 0; i < 20; i++) step("sat_lu", 1, 1'b0, 1'b0, 1'b0, V_LU);
    step("sat_end",  0, 1'b0, 1'b0, 1'b0, V_RUN);
    chk("sat_final", int'(stall_cycles), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
